// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the sequential multiplier
package mult_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int PARITY_MAX_W  = 64;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  // Zero-extension does not change an XOR reduction, so one wide argument serves every width.
  function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - unsigned shift-add datapath over operand magnitudes
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH:0]     a_mag,
  input  logic [WIDTH:0]     b_mag,
  output logic               last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load) begin
      mcand_d  = (2*WIDTH)'(a_mag);
      mplier_d = b_mag;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign last    = (cnt_q == CNT_W'(WIDTH-1));
  assign product = acc_q;

endmodule

// File: rtl/mult_seq_responder.sv
// rtl/mult_seq_responder.sv - req/ack responder: parity check, sequential signed multiply
module mult_seq_responder
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  output logic               ack,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               result_rdy,
  output logic               arg_parity_error
);

  mult_state_t        state_q, state_d;
  logic               ack_q, ack_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               result_parity_q, result_parity_d;
  logic               result_rdy_q, result_rdy_d;
  logic               arg_parity_error_q, arg_parity_error_d;
  logic               sign_q, sign_d;
  logic               err_pend_q, err_pend_d;

  logic               dp_load, dp_step, dp_last;
  logic [2*WIDTH-1:0] dp_product;
  logic [WIDTH:0]     a_ext, b_ext, a_mag, b_mag;
  logic               args_ok;

  // One extra bit lets the magnitude of the most negative operand be represented.
  assign a_ext   = {arg_a[WIDTH-1], arg_a};
  assign b_ext   = {arg_b[WIDTH-1], arg_b};
  assign a_mag   = a_ext[WIDTH] ? -a_ext : a_ext;
  assign b_mag   = b_ext[WIDTH] ? -b_ext : b_ext;
  assign args_ok = (parity(PARITY_MAX_W'(arg_a)) == arg_a_parity) &&
                   (parity(PARITY_MAX_W'(arg_b)) == arg_b_parity);

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (dp_load),
    .step    (dp_step),
    .a_mag   (a_mag),
    .b_mag   (b_mag),
    .last    (dp_last),
    .product (dp_product)
  );

  always_comb begin
    state_d            = state_q;
    ack_d              = 1'b0;
    result_rdy_d       = 1'b0;
    result_d           = result_q;
    result_parity_d    = result_parity_q;
    arg_parity_error_d = arg_parity_error_q;
    sign_d             = sign_q;
    err_pend_d         = err_pend_q;
    dp_load            = 1'b0;
    dp_step            = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          ack_d = 1'b1;
          if (args_ok) begin
            dp_load    = 1'b1;
            sign_d     = arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
            err_pend_d = 1'b0;
            state_d    = CALC;
          end else begin
            err_pend_d = 1'b1;
            state_d    = DONE;
          end
        end
      end
      CALC: begin
        dp_step = 1'b1;
        if (dp_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        result_rdy_d = 1'b1;
        state_d      = IDLE;
        if (err_pend_q) begin
          result_d           = '0;
          result_parity_d    = 1'b0;
          arg_parity_error_d = 1'b1;
        end else begin
          result_d           = sign_q ? -dp_product : dp_product;
          result_parity_d    = parity(PARITY_MAX_W'(result_d));
          arg_parity_error_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      ack_q              <= 1'b0;
      result_q           <= '0;
      result_parity_q    <= 1'b0;
      result_rdy_q       <= 1'b0;
      arg_parity_error_q <= 1'b0;
      sign_q             <= 1'b0;
      err_pend_q         <= 1'b0;
    end else begin
      state_q            <= state_d;
      ack_q              <= ack_d;
      result_q           <= result_d;
      result_parity_q    <= result_parity_d;
      result_rdy_q       <= result_rdy_d;
      arg_parity_error_q <= arg_parity_error_d;
      sign_q             <= sign_d;
      err_pend_q         <= err_pend_d;
    end
  end

  assign ack              = ack_q;
  assign result           = result_q;
  assign result_parity    = result_parity_q;
  assign result_rdy       = result_rdy_q;
  assign arg_parity_error = arg_parity_error_q;

endmodule

// File: tb/tb_mult_seq_responder.sv
// tb/tb_mult_seq_responder.sv - directed and random checks of mult_seq_responder
module tb_mult_seq_responder;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req;
  logic [W-1:0]   arg_a, arg_b;
  logic           arg_a_parity, arg_b_parity;
  logic           ack;
  logic [2*W-1:0] result;
  logic           result_parity, result_rdy, arg_parity_error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mult_seq_responder #(.WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (req),
    .arg_a            (arg_a),
    .arg_a_parity     (arg_a_parity),
    .arg_b            (arg_b),
    .arg_b_parity     (arg_b_parity),
    .ack              (ack),
    .result           (result),
    .result_parity    (result_parity),
    .result_rdy       (result_rdy),
    .arg_parity_error (arg_parity_error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_product(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ack"}, 32'(ack), 32'd0);
    check({tag, ".rdy"}, 32'(result_rdy), 32'd0);
    check({tag, ".result"}, result, 32'd0);
    check({tag, ".par"}, 32'(result_parity), 32'd0);
    check({tag, ".err"}, 32'(arg_parity_error), 32'd0);
  endtask

  task automatic run_txn(input string tag,
                         input logic [W-1:0] a, input logic ap,
                         input logic [W-1:0] b, input logic bp,
                         input logic [31:0] exp_res, input logic exp_par, input logic exp_err);
    int lat;
    bit seen;
    arg_a = a; arg_a_parity = ap;
    arg_b = b; arg_b_parity = bp;
    req = 1'b1;
    @(negedge clk);
    check({tag, ".ack"}, 32'(ack), 32'd1);
    req = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, ".ack_pulse"}, 32'(ack), 32'd0);
      if (result_rdy === 1'b1) seen = 1'b1;
    end
    check({tag, ".latency"}, 32'(lat), exp_err ? 32'd1 : 32'(W + 1));
    check({tag, ".result"}, result, exp_res);
    check({tag, ".par"}, 32'(result_parity), 32'(exp_par));
    check({tag, ".err"}, 32'(arg_parity_error), 32'(exp_err));
    @(negedge clk);
    check({tag, ".rdy_pulse"}, 32'(result_rdy), 32'd0);
    check({tag, ".held"}, result, exp_res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         fa, fb, eerr;
    logic [31:0]  eres;
    int           rdy_seen;

    rst_n = 1'b0;
    req = 1'b1;
    arg_a = 16'h0003; arg_a_parity = 1'b0;
    arg_b = 16'hFFFB; arg_b_parity = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle_outputs("reset");
    end
    req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_txn("signed", 16'h0003, 1'b0, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0);
    run_txn("neg_ext", 16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
    run_txn("par_err", 16'h0003, 1'b1, 16'h0002, 1'b1, 32'h0, 1'b0, 1'b1);
    run_txn("zero", 16'h0000, 1'b0, 16'h1234, 1'b1, 32'h0, 1'b0, 1'b0);
    run_txn("mixed_ext", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 32'hC000_8000, 1'b1, 1'b0);

    arg_a = 16'd5; arg_a_parity = 1'b0;
    arg_b = 16'd7; arg_b_parity = 1'b1;
    req = 1'b1;
    @(negedge clk);
    check("abort.ack", 32'(ack), 32'd1);
    req = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("abort.in_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_rdy === 1'b1) rdy_seen++;
    end
    check("abort.no_rdy", 32'(rdy_seen), 32'd0);
    check_idle_outputs("abort.after");
    run_txn("after_abort", 16'd5, 1'b0, 16'd7, 1'b1, 32'd35, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 7) == 0) ra = '0;
      if ($urandom_range(0, 7) == 0) rb = '0;
      fa = ($urandom_range(0, 4) == 0);
      fb = ($urandom_range(0, 4) == 0);
      eerr = fa | fb;
      eres = eerr ? 32'd0 : model_product(ra, rb);
      run_txn($sformatf("rand%0d", i), ra, (^ra) ^ fa, rb, (^rb) ^ fb,
              eres, eerr ? 1'b0 : ^eres, eerr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
